alut_age_checker6: RTL and testbench
====================================

# alut_age_checker6

Age checker for the ALUT, directly downstream of the address checker. It answers the address checker's per-frame in-date queries (`check_age6`/`last_accessed6` in, `age_confirmed6`/`age_ok6` out). On SW command it also sweeps all 256 ALUT locations and invalidates every valid entry older than the programmed maximum age. It shares the ALUT memory with the address checker, which always has priority.

## Interface
- Parameters: none. Table depth is fixed at 256 entries; entry format is {valid[82], time[81:50], port[49:48], addr[47:0]}.
- pclk6  in  1  APB clock.
- n_p_reset6  in  1  asynchronous, active-low reset.
- command  in  2  2'b10 = start age sweep; other values are ignored by this block.
- check_age6  in  1  single-cycle age query request from the address checker.
- last_accessed6  in  32  timestamp to check; valid in the same cycle as check_age6.
- curr_time6  in  32  free-running current time.
- best_bfr_age6  in  32  maximum permitted age.
- add_check_active6  in  1  address checker owns the memory.
- mem_read_data_age6  in  83  memory read data, valid 1 cycle after the address is presented.
- age_confirmed6  out  1  one-cycle pulse: query result valid.
- age_ok6  out  1  query result, 1 = in date; qualified by age_confirmed6.
- age_check_active6  out  1  sweep in progress (status bit 1).
- mem_addr_age6  out  8  memory address.
- mem_write_age6  out  1  write strobe, high = write.
- mem_write_data_age6  out  83  memory write data.
- lst_inv_addr_cmd6  out  48  address of the last entry invalidated by a sweep.
- lst_inv_port_cmd6  out  2  port of the last entry invalidated by a sweep.

## Operation
- Age arithmetic:
  - age = curr_time6 − timestamp, computed as a 32-bit unsigned modulo-2^32 subtraction, so timer wrap-around is handled.
  - An entry is in date when age ≤ best_bfr_age6. Equality counts as in date.
- Query path: independent of the sweep and always serviced.
  - check_age6 is sampled at edge t.
  - age_confirmed6 = 1 for the single cycle after t.
  - age_ok6 is registered from last_accessed6/curr_time6 sampled at t and holds its value until the next query.
- Sweep FSM states: IDLE, SW_READ, SW_WAIT, SW_EVAL, SW_WRITE. An 8-bit index register tracks the current location.
- IDLE:
  - command==2'b10 → SW_READ with index=0.
  - age_check_active6 = (state != IDLE).
- SW_READ:
  - If add_check_active6=0: drive mem_addr_age6=index with write=0 → SW_WAIT.
  - Otherwise hold in SW_READ.
- SW_WAIT: → SW_EVAL, because read data is valid in SW_EVAL.
- SW_EVAL, when data[82]=1 and the entry is stale:
  - Latch lst_inv_addr_cmd6=data[47:0] and lst_inv_port_cmd6=data[49:48].
  - Form write data {1'b0, data[81:0]} → SW_WRITE.
- SW_EVAL, otherwise (entry invalid or in date):
  - index==255 → IDLE.
  - Otherwise index+1 → SW_READ.
- SW_WRITE:
  - mem_write_age6=1 and mem_addr_age6=index for one cycle.
  - Then → IDLE if index==255, else index+1 → SW_READ.
- Memory conflict: if add_check_active6 rises in SW_WAIT, SW_EVAL or SW_WRITE, the access is abandoned without writing and the FSM returns to SW_READ with the same index. mem_write_age6 must never be 1 while add_check_active6=1.
- command==2'b10 during a sweep is ignored; no restart.
- Index 255 terminates the sweep. The index never wraps to 0 within a sweep.
- When not writing: mem_write_age6=0, mem_write_data_age6 holds its last value, mem_addr_age6 holds index.

## Timing
- Reset values:
  - All outputs 0: age_confirmed6, age_ok6, age_check_active6, mem_addr_age6, mem_write_age6, mem_write_data_age6, lst_inv_addr_cmd6, lst_inv_port_cmd6.
  - FSM in IDLE, index 0.
- Query latency is exactly 1 cycle. Back-to-back check_age6 pulses yield back-to-back age_confirmed6 pulses.
- Uncontended sweep cost per entry:
  - 3 cycles for an entry that is kept.
  - 4 cycles for an entry that is invalidated.
  - A clean 256-entry sweep takes 768 cycles from SW_READ to IDLE.
- age_check_active6 rises the cycle after the command is sampled and falls the cycle after the final SW_EVAL or SW_WRITE.
- Reset mid-sweep aborts immediately: FSM to IDLE, no write issued, lst_inv_* cleared.
- A query coincident with any sweep state is serviced with unchanged latency.

## Test plan
- Query in date: curr_time6=0x100, last_accessed6=0x0F0, best_bfr_age6=0x10, check_age6 pulse → next cycle age_confirmed6=1, age_ok6=1. Repeat with last_accessed6=0x0EF → age_ok6=0.
- Timer wrap: curr_time6=0x00000005, last_accessed6=0xFFFFFFFB, best_bfr_age6=10 → age=10, age_ok6=1.
- Full sweep: memory loaded with valid entries time=0, except index 0x42 with time=0x500, addr=0x0A0B0C0D0E0F, port=2; curr_time6=0x600, best_bfr_age6=0x200.
  - Every location except 0x42 is rewritten with bit 82=0; location 0x42 is untouched.
  - lst_inv_* holds the last invalidated entry (index 0xFF).
  - Sweep duration is 3·1 + 4·255 = 1023 cycles.
- Contention: hold add_check_active6=1 for 20 cycles while the FSM sits in SW_EVAL at index 7 → no write, FSM returns to SW_READ with index 7, then completes normally after release.
- Reset mid-sweep at index 0x80 → all outputs 0 immediately. A new command 2'b10 then restarts at index 0.
- command 2'b10 reissued mid-sweep → ignored; the index continues monotonically to 255.

Source files
------------

// File: rtl/alut_age_checker6_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alut_age_checker6_if : age-query handshake and shared ALUT memory port
// Revision 1.0
// ---------------------------------------------------------------------------
interface alut_age_checker6_if;
    logic        check_age6;
    logic [31:0] last_accessed6;
    logic        age_confirmed6;
    logic        age_ok6;
    logic        add_check_active6;
    logic [82:0] mem_read_data_age6;
    logic [7:0]  mem_addr_age6;
    logic        mem_write_age6;
    logic [82:0] mem_write_data_age6;

    modport slave (
        input  check_age6, last_accessed6, add_check_active6, mem_read_data_age6,
        output age_confirmed6, age_ok6, mem_addr_age6, mem_write_age6, mem_write_data_age6
    );

    modport master (
        output check_age6, last_accessed6, add_check_active6, mem_read_data_age6,
        input  age_confirmed6, age_ok6, mem_addr_age6, mem_write_age6, mem_write_data_age6
    );
endinterface
`default_nettype wire

// File: rtl/alut_age_checker6.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alut_age_checker6 : ALUT age query responder and SW-triggered stale sweep
// Revision 1.0
// ---------------------------------------------------------------------------
module alut_age_checker6 (
    input  wire logic                pclk6,
    input  wire logic                n_p_reset6,
    input  wire logic [1:0]          command,
    input  wire logic [31:0]         curr_time6,
    input  wire logic [31:0]         best_bfr_age6,
    alut_age_checker6_if.slave       bus,
    output logic                     age_check_active6,
    output logic [47:0]              lst_inv_addr_cmd6,
    output logic [1:0]               lst_inv_port_cmd6
);

    localparam logic [1:0] c_CMD_SWEEP = 2'b10;
    localparam logic [7:0] c_LAST_IDX  = 8'hFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SW_READ  = 3'd1,
        SW_WAIT  = 3'd2,
        SW_EVAL  = 3'd3,
        SW_WRITE = 3'd4
    } state_t;

    state_t      r_state;
    logic [7:0]  r_index;
    logic        r_write;
    logic [82:0] r_wdata;
    logic        r_age_confirmed;
    logic        r_age_ok;
    logic [47:0] r_lst_addr;
    logic [1:0]  r_lst_port;

    logic        w_aca;
    logic [82:0] w_rd;
    logic        w_stale;

    // Modulo-2^32 difference keeps the check correct across timer wrap.
    function automatic logic in_date(input logic [31:0] now_t,
                                     input logic [31:0] stamp,
                                     input logic [31:0] max_age);
        logic [31:0] age;
        age = now_t - stamp;
        return (age <= max_age);
    endfunction

    assign w_aca   = bus.add_check_active6;
    assign w_rd    = bus.mem_read_data_age6;
    assign w_stale = w_rd[82] && !in_date(curr_time6, w_rd[81:50], best_bfr_age6);

    always_ff @(posedge pclk6 or negedge n_p_reset6) begin
        if (!n_p_reset6) begin
            r_age_confirmed <= 1'b0;
            r_age_ok        <= 1'b0;
        end else begin
            r_age_confirmed <= bus.check_age6;
            if (bus.check_age6)
                r_age_ok <= in_date(curr_time6, bus.last_accessed6, best_bfr_age6);
        end
    end

    always_ff @(posedge pclk6 or negedge n_p_reset6) begin
        if (!n_p_reset6) begin
            r_state    <= IDLE;
            r_index    <= 8'd0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_lst_addr <= '0;
            r_lst_port <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (command == c_CMD_SWEEP) begin
                        r_index <= 8'd0;
                        r_state <= SW_READ;
                    end
                end
                SW_READ: begin
                    if (!w_aca)
                        r_state <= SW_WAIT;
                end
                SW_WAIT: begin
                    r_state <= w_aca ? SW_READ : SW_EVAL;
                end
                SW_EVAL: begin
                    if (w_aca) begin
                        r_state <= SW_READ;
                    end else if (w_stale) begin
                        r_lst_addr <= w_rd[47:0];
                        r_lst_port <= w_rd[49:48];
                        r_wdata    <= {1'b0, w_rd[81:0]};
                        r_write    <= 1'b1;
                        r_state    <= SW_WRITE;
                    end else if (r_index == c_LAST_IDX) begin
                        r_state <= IDLE;
                    end else begin
                        r_index <= r_index + 8'd1;
                        r_state <= SW_READ;
                    end
                end
                SW_WRITE: begin
                    r_write <= 1'b0;
                    // A contended write is dropped and the location re-read.
                    if (w_aca) begin
                        r_state <= SW_READ;
                    end else if (r_index == c_LAST_IDX) begin
                        r_state <= IDLE;
                    end else begin
                        r_index <= r_index + 8'd1;
                        r_state <= SW_READ;
                    end
                end
                default: begin
                    r_write <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Combinational gate guarantees no write can coincide with address-checker ownership.
    assign bus.mem_write_age6      = r_write & ~w_aca;
    assign bus.mem_addr_age6       = r_index;
    assign bus.mem_write_data_age6 = r_wdata;
    assign bus.age_confirmed6      = r_age_confirmed;
    assign bus.age_ok6             = r_age_ok;
    assign age_check_active6       = (r_state != IDLE);
    assign lst_inv_addr_cmd6       = r_lst_addr;
    assign lst_inv_port_cmd6       = r_lst_port;

endmodule
`default_nettype wire

// File: tb/tb_alut_age_checker6.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alut_age_checker6 : query vector table + scoreboard, sweep/contention/reset sequences
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_alut_age_checker6;

    logic        pclk6 = 1'b0;
    logic        n_p_reset6 = 1'b0;
    logic [1:0]  command = 2'b00;
    logic [31:0] curr_time6 = 32'd0;
    logic [31:0] best_bfr_age6 = 32'd0;
    logic        age_check_active6;
    logic [47:0] lst_inv_addr_cmd6;
    logic [1:0]  lst_inv_port_cmd6;

    alut_age_checker6_if bus();

    alut_age_checker6 dut (
        .pclk6             (pclk6),
        .n_p_reset6        (n_p_reset6),
        .command           (command),
        .curr_time6        (curr_time6),
        .best_bfr_age6     (best_bfr_age6),
        .bus               (bus),
        .age_check_active6 (age_check_active6),
        .lst_inv_addr_cmd6 (lst_inv_addr_cmd6),
        .lst_inv_port_cmd6 (lst_inv_port_cmd6)
    );

    always #5 pclk6 = ~pclk6;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Synchronous ALUT memory model: read data valid the cycle after the address.
    logic [82:0] mem  [256];
    logic [82:0] orig [256];
    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr = 8'd0;
    logic [82:0] ld_data = '0;
    int          wr_count = 0;

    always @(posedge pclk6) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (bus.mem_write_age6) begin
            mem[bus.mem_addr_age6] <= bus.mem_write_data_age6;
            wr_count <= wr_count + 1;
        end
        bus.mem_read_data_age6 <= mem[bus.mem_addr_age6];
    end

    // Scoreboard of expected query results.
    logic exp_q[$];

    always @(negedge pclk6) begin
        logic e;
        if (n_p_reset6 && bus.age_confirmed6) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL query_unexpected: got age_confirmed6=1 expected no pending query");
            end else begin
                e = exp_q.pop_front();
                check("query_ok", bus.age_ok6, e);
            end
        end
    end

    always @(negedge pclk6) begin
        if (bus.mem_write_age6)
            check("write_guard", {bus.add_check_active6, bus.mem_write_data_age6[82]}, 2'b00);
    end

    function automatic logic [82:0] entry(input int i, input logic [31:0] t);
        logic [7:0] b;
        b = 8'(i);
        return {1'b1, t, b[1:0], 40'd0, b};
    endfunction

    // mode 0: stale except 0x42; mode 1: in date except 7; mode 2: all stale
    task automatic load(input int mode);
        @(posedge pclk6); #1;
        for (int i = 0; i < 256; i++) begin
            logic [82:0] d;
            if (mode == 0)      d = (i == 8'h42) ? {1'b1, 32'h500, 2'd2, 48'h0A0B0C0D0E0F} : entry(i, 32'h0);
            else if (mode == 1) d = (i == 7) ? entry(i, 32'h0) : entry(i, 32'h5F0);
            else                d = entry(i, 32'h0);
            orig[i] = d;
            ld_en = 1'b1; ld_addr = 8'(i); ld_data = d;
            @(posedge pclk6); #1;
        end
        ld_en = 1'b0;
    endtask

    task automatic start_sweep();
        command = 2'b10;
        @(posedge pclk6); #1;
        command = 2'b00;
        @(negedge pclk6);
        check("sweep_rise", age_check_active6, 1'b1);
        check("sweep_start_idx", bus.mem_addr_age6, 8'd0);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int b;
        b = 0;
        while (age_check_active6 && b < budget) begin
            @(negedge pclk6);
            b++;
        end
        check(name, age_check_active6, 1'b0);
    endtask

    typedef struct {
        logic [31:0] last;
        logic [31:0] curr;
        logic [31:0] best;
        logic        ok;
    } qvec_t;

    qvec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int cycles, nonmono, bad, wr0, b;
        logic [7:0] prev;

        vecs[0] = '{32'h0F0,      32'h100,      32'h10,       1'b1};
        vecs[1] = '{32'h0EF,      32'h100,      32'h10,       1'b0};
        vecs[2] = '{32'hFFFFFFFB, 32'h5,        32'd10,       1'b1};
        vecs[3] = '{32'hFFFFFFFA, 32'h5,        32'd10,       1'b0};
        vecs[4] = '{32'h0,        32'h0,        32'h0,        1'b1};
        vecs[5] = '{32'h2,        32'h1,        32'hFFFFFFFE, 1'b0};
        vecs[6] = '{32'h0,        32'h80000000, 32'hFFFFFFFF, 1'b1};
        vecs[7] = '{32'h1234,     32'h1234,     32'h0,        1'b1};

        bus.check_age6 = 1'b0;
        bus.last_accessed6 = '0;
        bus.add_check_active6 = 1'b0;

        repeat (3) @(posedge pclk6);
        #1;
        check("rst_confirmed", bus.age_confirmed6, 1'b0);
        check("rst_ok", bus.age_ok6, 1'b0);
        check("rst_active", age_check_active6, 1'b0);
        check("rst_addr", bus.mem_addr_age6, 8'd0);
        check("rst_write", bus.mem_write_age6, 1'b0);
        check("rst_wdata", bus.mem_write_data_age6, 83'd0);
        check("rst_lst_addr", lst_inv_addr_cmd6, 48'd0);
        check("rst_lst_port", lst_inv_port_cmd6, 2'd0);
        n_p_reset6 = 1'b1;
        @(posedge pclk6); #1;

        // Back-to-back query table
        for (int i = 0; i < 8; i++) begin
            bus.check_age6 = 1'b1;
            bus.last_accessed6 = vecs[i].last;
            curr_time6 = vecs[i].curr;
            best_bfr_age6 = vecs[i].best;
            exp_q.push_back(vecs[i].ok);
            @(posedge pclk6); #1;
        end
        bus.check_age6 = 1'b0;
        repeat (3) @(negedge pclk6);
        check("query_drain", exp_q.size(), 0);
        check("query_hold_ok", bus.age_ok6, vecs[7].ok);
        check("query_hold_conf", bus.age_confirmed6, 1'b0);

        // Full sweep with a reissued command and queries mid-sweep
        load(0);
        curr_time6 = 32'h600;
        best_bfr_age6 = 32'h200;
        wr0 = wr_count;
        start_sweep();
        cycles = 1; nonmono = 0; prev = 8'd0;
        fork
            begin
                while (age_check_active6 && cycles < 3000) begin
                    @(negedge pclk6);
                    if (age_check_active6) begin
                        cycles++;
                        if (bus.mem_addr_age6 < prev) nonmono++;
                        prev = bus.mem_addr_age6;
                    end
                end
            end
            begin
                repeat (300) @(posedge pclk6);
                #1 command = 2'b10;
                @(posedge pclk6); #1;
                command = 2'b00;
                bus.check_age6 = 1'b1; bus.last_accessed6 = 32'h400; exp_q.push_back(1'b1);
                @(posedge pclk6); #1;
                bus.last_accessed6 = 32'h3FF; exp_q.push_back(1'b0);
                @(posedge pclk6); #1;
                bus.last_accessed6 = 32'h5FF; exp_q.push_back(1'b1);
                @(posedge pclk6); #1;
                bus.check_age6 = 1'b0;
            end
        join
        check("sweep_cycles", cycles, 1023);
        check("sweep_monotonic", nonmono, 0);
        check("sweep_end_idx", prev, 8'hFF);
        check("sweep_writes", wr_count - wr0, 255);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (i != 8'h42 && mem[i] !== {1'b0, orig[i][81:0]}) bad++;
        check("sweep_contents", bad, 0);
        check("sweep_kept_42", mem[8'h42], orig[8'h42]);
        check("sweep_lst_addr", lst_inv_addr_cmd6, 48'hFF);
        check("sweep_lst_port", lst_inv_port_cmd6, 2'd3);
        check("sweep_query_drain", exp_q.size(), 0);

        // Contention while sitting in SW_EVAL at index 7
        load(1);
        wr0 = wr_count;
        start_sweep();
        b = 0;
        while (bus.mem_addr_age6 != 8'd7 && b < 100) begin
            @(negedge pclk6);
            b++;
        end
        check("cont_reach_7", bus.mem_addr_age6, 8'd7);
        @(posedge pclk6);
        @(posedge pclk6); #1;
        bus.add_check_active6 = 1'b1;
        repeat (19) @(posedge pclk6);
        @(negedge pclk6);
        check("cont_hold_idx", bus.mem_addr_age6, 8'd7);
        check("cont_hold_active", age_check_active6, 1'b1);
        check("cont_no_write", wr_count - wr0, 0);
        @(posedge pclk6); #1;
        bus.add_check_active6 = 1'b0;
        wait_idle("cont_complete", 2000);
        check("cont_writes", wr_count - wr0, 1);
        check("cont_mem7", mem[7], {1'b0, orig[7][81:0]});
        check("cont_mem8", mem[8], orig[8]);
        check("cont_lst_addr", lst_inv_addr_cmd6, 48'd7);
        check("cont_lst_port", lst_inv_port_cmd6, 2'd3);

        // Reset in the middle of a sweep at index 0x80
        load(2);
        start_sweep();
        b = 0;
        while (bus.mem_addr_age6 != 8'h80 && b < 1000) begin
            @(negedge pclk6);
            b++;
        end
        check("mid_reach_80", bus.mem_addr_age6, 8'h80);
        n_p_reset6 = 1'b0;
        #1;
        check("mid_rst_active", age_check_active6, 1'b0);
        check("mid_rst_addr", bus.mem_addr_age6, 8'd0);
        check("mid_rst_write", bus.mem_write_age6, 1'b0);
        check("mid_rst_wdata", bus.mem_write_data_age6, 83'd0);
        check("mid_rst_lst_addr", lst_inv_addr_cmd6, 48'd0);
        check("mid_rst_lst_port", lst_inv_port_cmd6, 2'd0);
        check("mid_rst_ok", bus.age_ok6, 1'b0);
        wr0 = wr_count;
        @(posedge pclk6); #1;
        n_p_reset6 = 1'b1;
        repeat (3) @(posedge pclk6);
        #1;
        check("mid_rst_no_write", wr_count - wr0, 0);
        check("mid_rst_mem80", mem[8'h80], orig[8'h80]);
        start_sweep();
        wait_idle("restart_complete", 3000);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== {1'b0, orig[i][81:0]}) bad++;
        check("restart_contents", bad, 0);
        check("restart_lst_addr", lst_inv_addr_cmd6, 48'hFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
